// File: rtl/regfile_port_arbiter_if.sv
// Bus bundle for regfile_port_arbiter: CPU and debug request/response
// channels plus the shared register-file port b.
interface regfile_port_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;

  logic       dbg_req;
  logic       dbg_we;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata;
  logic       dbg_gnt;
  logic       dbg_rvalid;
  logic [7:0] dbg_rdata;
  logic       dbg_err;

  logic [4:0] rf_b_addr;
  logic [7:0] rf_b_data_in;
  logic       rf_b_wr_en;
  logic [7:0] rf_b_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output rf_b_addr, rf_b_data_in, rf_b_wr_en,
    input  rf_b_data_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  rf_b_addr, rf_b_data_in, rf_b_wr_en,
    output rf_b_data_out
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares register-file port b between the CPU (fixed priority) and the debug
// path, with an anti-starvation counter and one-cycle registered responses.
module regfile_port_arbiter #(
  parameter int         MAX_WAIT  = 8,
  parameter logic [4:0] FLAG_ADDR = 5'd31,
  parameter logic [4:0] DINP_ADDR = 5'd28
) (
  input  logic                   clk,
  input  logic                   resetn,
  regfile_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] starve_q, starve_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [7:0]    dbg_rdata_q, dbg_rdata_d;
  logic          dbg_err_q, dbg_err_d;

  logic starveMax;
  logic dbgWins;
  logic cpuGnt;
  logic dbgGnt;
  logic dbgBlocked;

  // Grants are gated by resetn so every output reads 0 while reset is held.
  always_comb begin
    starveMax  = (starve_q == CW'(MAX_WAIT));
    dbgWins    = bus.dbg_req && (!bus.cpu_req || starveMax);
    cpuGnt     = resetn && bus.cpu_req && !dbgWins;
    dbgGnt     = resetn && dbgWins;
    dbgBlocked = bus.dbg_we && ((bus.dbg_addr == FLAG_ADDR) || (bus.dbg_addr == DINP_ADDR));
  end

  always_comb begin
    bus.rf_b_addr    = 5'd0;
    bus.rf_b_data_in = 8'd0;
    bus.rf_b_wr_en   = 1'b0;
    if (cpuGnt) begin
      bus.rf_b_addr    = bus.cpu_addr;
      bus.rf_b_data_in = bus.cpu_wdata;
      bus.rf_b_wr_en   = bus.cpu_we;
    end else if (dbgGnt) begin
      bus.rf_b_addr    = bus.dbg_addr;
      bus.rf_b_data_in = bus.dbg_wdata;
      bus.rf_b_wr_en   = bus.dbg_we && !dbgBlocked;
    end
  end

  always_comb begin
    starve_d     = starve_q;
    cpu_rvalid_d = cpuGnt && !bus.cpu_we;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rvalid_d = dbgGnt;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_err_d    = dbgGnt && dbgBlocked;

    if (!bus.dbg_req || dbgGnt) begin
      starve_d = '0;
    end else if (!starveMax) begin
      starve_d = starve_q + CW'(1);
    end

    if (cpuGnt && !bus.cpu_we) begin
      cpu_rdata_d = bus.rf_b_data_out;
    end
    if (dbgGnt) begin
      dbg_rdata_d = bus.dbg_we ? 8'd0 : bus.rf_b_data_out;
    end
  end

  // Reset discards any response still in flight for an aborted access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 8'd0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 8'd0;
      dbg_err_q    <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  assign bus.cpu_gnt    = cpuGnt;
  assign bus.dbg_gnt    = dbgGnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.dbg_err    = dbg_err_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: fixed vectors, hand-written
// corner sequences and constrained-random traffic against a behavioural model.
module tb_regfile_port_arbiter;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic resetn;

  regfile_port_arbiter_if bus();

  regfile_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment register file behind port b.
  logic [7:0] tbRf [32];
  always @(posedge clk) begin
    if (bus.rf_b_wr_en) tbRf[bus.rf_b_addr] <= bus.rf_b_data_in;
  end
  assign bus.rf_b_data_out = tbRf[bus.rf_b_addr];

  int errCount;
  int checkCount;

  // Behavioural model state.
  logic [7:0] mRf [32];
  int         waitCnt;
  logic       expCpuRvalid, expDbgRvalid, expDbgErr;
  logic [7:0] expCpuRdata, expDbgRdata;
  logic       lastCpuG, lastDbgG;

  // DUT values sampled by the last runCycle.
  logic       sCpuG, sDbgG, sWr, sCpuRv, sDbgRv, sDbgErr;
  logic [7:0] sCpuRd, sDbgRd;

  typedef struct {
    logic       cpuReq;
    logic       cpuWe;
    logic [4:0] cpuAddr;
    logic [7:0] cpuWdata;
    logic       dbgReq;
    logic       dbgWe;
    logic [4:0] dbgAddr;
    logic [7:0] dbgWdata;
    logic       expCpuGnt;
    logic       expDbgGnt;
    logic       expWrEn;
  } vector_t;

  vector_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [4:0] cAddr,
                               input logic [7:0] cData, input logic dReq, input logic dWe,
                               input logic [4:0] dAddr, input logic [7:0] dData);
    bus.cpu_req   = cReq;
    bus.cpu_we    = cWe;
    bus.cpu_addr  = cAddr;
    bus.cpu_wdata = cData;
    bus.dbg_req   = dReq;
    bus.dbg_we    = dWe;
    bus.dbg_addr  = dAddr;
    bus.dbg_wdata = dData;
  endtask

  task automatic modelReset();
    waitCnt      = 0;
    expCpuRvalid = 1'b0;
    expCpuRdata  = 8'd0;
    expDbgRvalid = 1'b0;
    expDbgRdata  = 8'd0;
    expDbgErr    = 1'b0;
    lastCpuG     = 1'b0;
    lastDbgG     = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cpu_gnt"}, 32'(bus.cpu_gnt), 32'd0);
    checkOutput({tag, " dbg_gnt"}, 32'(bus.dbg_gnt), 32'd0);
    checkOutput({tag, " cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
    checkOutput({tag, " cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
    checkOutput({tag, " dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'd0);
    checkOutput({tag, " dbg_rdata"}, 32'(bus.dbg_rdata), 32'd0);
    checkOutput({tag, " dbg_err"}, 32'(bus.dbg_err), 32'd0);
    checkOutput({tag, " rf_b_addr"}, 32'(bus.rf_b_addr), 32'd0);
    checkOutput({tag, " rf_b_data_in"}, 32'(bus.rf_b_data_in), 32'd0);
    checkOutput({tag, " rf_b_wr_en"}, 32'(bus.rf_b_wr_en), 32'd0);
  endtask

  // One clock cycle: inputs are already applied; compare at the falling edge
  // against the model, then advance the model to the next cycle.
  task automatic runCycle();
    logic       eCpuG, eDbgG, eWr, blocked;
    logic [4:0] eAddr;
    logic [7:0] eData;
    @(negedge clk);
    sCpuG = bus.cpu_gnt;  sDbgG = bus.dbg_gnt;  sWr = bus.rf_b_wr_en;
    sCpuRv = bus.cpu_rvalid; sCpuRd = bus.cpu_rdata;
    sDbgRv = bus.dbg_rvalid; sDbgRd = bus.dbg_rdata; sDbgErr = bus.dbg_err;

    checkOutput("cpu_rvalid", 32'(sCpuRv), 32'(expCpuRvalid));
    checkOutput("cpu_rdata", 32'(sCpuRd), 32'(expCpuRdata));
    checkOutput("dbg_rvalid", 32'(sDbgRv), 32'(expDbgRvalid));
    checkOutput("dbg_rdata", 32'(sDbgRd), 32'(expDbgRdata));
    checkOutput("dbg_err", 32'(sDbgErr), 32'(expDbgErr));

    eDbgG   = bus.dbg_req && (!bus.cpu_req || waitCnt >= MAX_WAIT);
    eCpuG   = bus.cpu_req && !eDbgG;
    blocked = bus.dbg_we && (bus.dbg_addr == 5'd31 || bus.dbg_addr == 5'd28);
    eAddr = 5'd0; eData = 8'd0; eWr = 1'b0;
    if (eCpuG) begin
      eAddr = bus.cpu_addr; eData = bus.cpu_wdata; eWr = bus.cpu_we;
    end else if (eDbgG) begin
      eAddr = bus.dbg_addr; eData = bus.dbg_wdata; eWr = bus.dbg_we && !blocked;
    end

    checkOutput("cpu_gnt", 32'(sCpuG), 32'(eCpuG));
    checkOutput("dbg_gnt", 32'(sDbgG), 32'(eDbgG));
    checkOutput("rf_b_addr", 32'(bus.rf_b_addr), 32'(eAddr));
    checkOutput("rf_b_data_in", 32'(bus.rf_b_data_in), 32'(eData));
    checkOutput("rf_b_wr_en", 32'(sWr), 32'(eWr));

    expCpuRvalid = eCpuG && !bus.cpu_we;
    if (expCpuRvalid) expCpuRdata = mRf[bus.cpu_addr];
    expDbgRvalid = eDbgG;
    expDbgErr    = eDbgG && blocked;
    if (eDbgG) expDbgRdata = bus.dbg_we ? 8'd0 : mRf[bus.dbg_addr];
    if (eWr) mRf[eAddr] = eData;
    waitCnt  = (bus.dbg_req && !eDbgG) ? waitCnt + 1 : 0;
    lastCpuG = eCpuG;
    lastDbgG = eDbgG;

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    int         dbgCount;
    errCount   = 0;
    checkCount = 0;
    for (int i = 0; i < 32; i++) begin
      v = 8'($urandom);
      tbRf[i] = v;
      mRf[i]  = v;
    end
    tbRf[5] = 8'h3C;
    mRf[5]  = 8'h3C;
    modelReset();

    resetn = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b1, 5'd29, 8'h12);
    #12;
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = '{1'b1, 1'b0, 5'd5,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd29, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd31, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd28, 8'h77, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd5,  8'h00, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd31, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd10, 8'h11, 1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 5'd10, 8'h00, 1'b1, 1'b1, 5'd10, 8'h99, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd10, 8'h99, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd29, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 5'd31, 8'hC3, 1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].cpuReq, vecs[i].cpuWe, vecs[i].cpuAddr, vecs[i].cpuWdata,
                    vecs[i].dbgReq, vecs[i].dbgWe, vecs[i].dbgAddr, vecs[i].dbgWdata);
      runCycle();
      checkOutput($sformatf("vec%0d cpu_gnt", i), 32'(sCpuG), 32'(vecs[i].expCpuGnt));
      checkOutput($sformatf("vec%0d dbg_gnt", i), 32'(sDbgG), 32'(vecs[i].expDbgGnt));
      checkOutput($sformatf("vec%0d wr_en", i), 32'(sWr), 32'(vecs[i].expWrEn));
      if (i == 1) begin
        checkOutput("case1 cpu_rvalid", 32'(sCpuRv), 32'd1);
        checkOutput("case1 cpu_rdata", 32'(sCpuRd), 32'h3C);
      end
      if (i == 2) begin
        checkOutput("case2 dbg_rvalid", 32'(sDbgRv), 32'd1);
        checkOutput("case2 dbg_err", 32'(sDbgErr), 32'd0);
      end
      if (i == 3 || i == 4) begin
        checkOutput("case3 dbg_rvalid", 32'(sDbgRv), 32'd1);
        checkOutput("case3 dbg_err", 32'(sDbgErr), 32'd1);
      end
    end

    // Both requesters held: CPU eight times, debug on the ninth, repeating.
    dbgCount = 0;
    applyStimulus(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00);
    for (int i = 0; i < 27; i++) begin
      runCycle();
      checkOutput($sformatf("starve cyc%0d dbg_gnt", i), 32'(sDbgG), 32'((i % 9) == 8));
      if (sDbgG) dbgCount++;
    end
    checkOutput("starve dbg total", 32'(dbgCount), 32'd3);

    // Simultaneous single requests, then CPU drops and debug follows.
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    runCycle();
    applyStimulus(1'b1, 1'b0, 5'd4, 8'h00, 1'b1, 1'b0, 5'd6, 8'h00);
    runCycle();
    checkOutput("case5 first cpu_gnt", 32'(sCpuG), 32'd1);
    checkOutput("case5 first dbg_gnt", 32'(sDbgG), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd6, 8'h00);
    runCycle();
    checkOutput("case5 second dbg_gnt", 32'(sDbgG), 32'd1);

    // Reset asserted in the cycle after a read grant.
    applyStimulus(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    runCycle();
    resetn = 1'b0;
    #2;
    checkAllZero("midreset");
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 5'd5, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    runCycle();
    checkOutput("case6 cpu_gnt", 32'(sCpuG), 32'd1);
    checkOutput("case6 no stale rvalid", 32'(sCpuRv), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    runCycle();
    checkOutput("case6 cpu_rvalid", 32'(sCpuRv), 32'd1);
    checkOutput("case6 cpu_rdata", 32'(sCpuRd), 32'(mRf[5]));

    // Random traffic; a requester keeps its request until the model grants it.
    for (int n = 0; n < 400; n++) begin
      if (!bus.cpu_req || lastCpuG) begin
        bus.cpu_req   = ($urandom_range(0, 99) < 60);
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 5'($urandom);
        bus.cpu_wdata = 8'($urandom);
      end
      if (!bus.dbg_req || lastDbgG) begin
        bus.dbg_req   = ($urandom_range(0, 99) < 55);
        bus.dbg_we    = 1'($urandom);
        case ($urandom_range(0, 3))
          0:       bus.dbg_addr = 5'd31;
          1:       bus.dbg_addr = 5'd28;
          default: bus.dbg_addr = 5'($urandom);
        endcase
        bus.dbg_wdata = 8'($urandom);
      end
      runCycle();
    end

    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    runCycle();
    runCycle();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
